cipher_host_bridge: RTL and testbench

CIPHER_HOST_BRIDGE -- requirements
Module: cipher_host_bridge

---
 rtl/cipher_host_bridge_pkg.sv | 31 +++
 rtl/cipher_byte_fifo.sv | 60 ++++++
 rtl/cipher_host_bridge.sv | 180 ++++++++++++++++++
 tb/tb_cipher_host_bridge.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cipher_host_bridge_pkg.sv
// Shared types for the cipher host bridge.
//   bridge_state_t   : bridge handshake FSM states
//   cipher_cmd_t     : one command toward the cipher core (byte + flags)
//   cnt_width()      : width of an occupancy counter for a given depth
package cipher_host_bridge_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReqHi,
    StReqLo,
    StOutWait,
    StOutAck
  } bridge_state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       is_key;
    logic       reset_hash;
  } cipher_cmd_t;

  // Only plain data bytes yield a ciphertext byte from the core.
  function automatic logic is_data_cmd(cipher_cmd_t cmd);
    return !cmd.is_key && !cmd.reset_hash;
  endfunction

  // Counter must hold 0..depth inclusive.
  function automatic int unsigned cnt_width(int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/cipher_byte_fifo.sv
// Byte FIFO holding ciphertext on its way downstream.
//   i_clk, i_nrst          : clock, asynchronous active-low reset
//   i_push, i_push_data    : write one byte
//   i_pop                  : downstream ready; pops when o_valid is set
//   o_head, o_valid        : head entry and non-empty flag
//   o_count                : occupancy, 0..DEPTH
// DEPTH must be a power of two so pointers wrap by natural overflow.
module cipher_byte_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_nrst,
  input  logic                     i_push,
  input  logic [7:0]               i_push_data,
  input  logic                     i_pop,
  output logic [7:0]               o_head,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [7:0]      r_mem [DEPTH];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [PtrW:0]   r_count;
  logic            w_pop;
  logic            w_push;

  assign o_valid = (r_count != '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  assign w_pop  = i_pop && o_valid;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign w_push = i_push && ((r_count != (PtrW + 1)'(DEPTH)) || w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cipher_host_bridge.sv
// Bridge between a valid/ready byte stream and a cipher core using 4-phase
// handshakes on both its input and output sides.
//   clk, nrst                         : clock, asynchronous active-low reset
//   in_byte/in_is_key/in_reset_hash,
//   in_valid/in_ready                 : upstream command stream
//   core_input_byte/core_is_key/
//   core_reset_hash                   : registered command to the core
//   core_input_request/_acknowledged  : input-side handshake
//   core_output_byte_is_ready/
//   core_output_byte/_acknowledge     : output-side handshake
//   out_byte/out_valid/out_ready      : downstream ciphertext stream
//   fifo_count, timeout_err           : status
// Optional watchdog: define CIPHER_HOST_BRIDGE_TIMEOUT_EN to abort any
// handshake that stalls for TIMEOUT_CYCLES cycles in one state.
module cipher_host_bridge
  import cipher_host_bridge_pkg::*;
#(
  parameter int unsigned OUT_DEPTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                             clk,
  input  logic                             nrst,
  input  logic [7:0]                       in_byte,
  input  logic                             in_is_key,
  input  logic                             in_reset_hash,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [7:0]                       core_input_byte,
  output logic                             core_is_key,
  output logic                             core_reset_hash,
  output logic                             core_input_request,
  input  logic                             core_input_acknowledged,
  input  logic                             core_output_byte_is_ready,
  input  logic [7:0]                       core_output_byte,
  output logic                             core_output_acknowledge,
  output logic [7:0]                       out_byte,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [cnt_width(OUT_DEPTH)-1:0]  fifo_count,
  output logic                             timeout_err
);

  localparam int unsigned CntW = cnt_width(OUT_DEPTH);

  bridge_state_t   r_state;
  bridge_state_t   w_state_d;
  cipher_cmd_t     r_cmd;
  cipher_cmd_t     w_cmd_d;
  logic            r_req;
  logic            w_req_d;
  logic            r_oack;
  logic            w_oack_d;
  logic            w_push;
  logic            w_in_ready;
  logic            w_timeout;
  logic [CntW-1:0] w_fifo_count;

  // Accepting only with a free slot is what keeps the FIFO from overflowing:
  // exactly one byte can be in flight between acceptance and push.
  assign w_in_ready = (r_state == StIdle) && (w_fifo_count < CntW'(OUT_DEPTH));

  always_comb begin
    w_state_d = r_state;
    w_cmd_d   = r_cmd;
    w_req_d   = r_req;
    w_oack_d  = r_oack;
    w_push    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (in_valid && w_in_ready) begin
          w_cmd_d.data       = in_byte;
          w_cmd_d.is_key     = in_is_key;
          w_cmd_d.reset_hash = in_reset_hash;
          w_req_d            = 1'b1;
          w_state_d          = StReqHi;
        end
      end
      StReqHi: begin
        if (core_input_acknowledged) begin
          w_req_d   = 1'b0;
          w_state_d = StReqLo;
        end
      end
      StReqLo: begin
        if (!core_input_acknowledged) begin
          w_state_d = is_data_cmd(r_cmd) ? StOutWait : StIdle;
        end
      end
      StOutWait: begin
        if (core_output_byte_is_ready) begin
          w_push    = 1'b1;
          w_oack_d  = 1'b1;
          w_state_d = StOutAck;
        end
      end
      StOutAck: begin
        if (!core_output_byte_is_ready) begin
          w_oack_d  = 1'b0;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
    // Watchdog abort abandons the transaction, including any pending push.
    if (w_timeout) begin
      w_state_d = StIdle;
      w_req_d   = 1'b0;
      w_oack_d  = 1'b0;
      w_push    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= StIdle;
      r_cmd   <= '0;
      r_req   <= 1'b0;
      r_oack  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cmd   <= w_cmd_d;
      r_req   <= w_req_d;
      r_oack  <= w_oack_d;
    end
  end

`ifdef CIPHER_HOST_BRIDGE_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WdW-1:0] r_wd;
  logic           r_timeout_err;

  // r_wd counts completed cycles in the current state, so the abort lands
  // at the end of the TIMEOUT_CYCLES-th cycle spent there.
  assign w_timeout   = (r_state != StIdle) && (r_wd == WdW'(TIMEOUT_CYCLES - 1));
  assign timeout_err = r_timeout_err;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wd          <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_state_d != r_state) begin
        r_wd <= '0;
      end else if (r_state != StIdle) begin
        r_wd <= r_wd + 1'b1;
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end
`else
  assign w_timeout   = 1'b0;
  // The limit is still a legal parameter in this build; it simply has no effect.
  assign timeout_err = (TIMEOUT_CYCLES == 0) & 1'b0;
`endif

  cipher_byte_fifo #(
    .DEPTH(OUT_DEPTH)
  ) u_fifo (
    .i_clk      (clk),
    .i_nrst     (nrst),
    .i_push     (w_push),
    .i_push_data(core_output_byte),
    .i_pop      (out_ready),
    .o_head     (out_byte),
    .o_valid    (out_valid),
    .o_count    (w_fifo_count)
  );

  assign in_ready                = w_in_ready;
  assign core_input_byte         = r_cmd.data;
  assign core_is_key             = r_cmd.is_key;
  assign core_reset_hash         = r_cmd.reset_hash;
  assign core_input_request      = r_req;
  assign core_output_acknowledge = r_oack;
  assign fifo_count              = w_fifo_count;

endmodule

// File: tb/tb_cipher_host_bridge.sv
// Directed bench for cipher_host_bridge. The core side is driven by hand,
// one negedge at a time; outputs are sampled on the negedge.
module tb_cipher_host_bridge;
  import cipher_host_bridge_pkg::*;

  localparam int unsigned Depth = 4;
  localparam int unsigned Tmo   = 8;

  logic       clk = 1'b0;
  logic       nrst;
  logic [7:0] in_byte;
  logic       in_is_key;
  logic       in_reset_hash;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] core_input_byte;
  logic       core_is_key;
  logic       core_reset_hash;
  logic       core_input_request;
  logic       core_input_acknowledged;
  logic       core_output_byte_is_ready;
  logic [7:0] core_output_byte;
  logic       core_output_acknowledge;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] fifo_count;
  logic       timeout_err;

  int total = 0;
  int bad   = 0;
  int req_rises = 0;
  int oack_cycles = 0;
  logic req_prev = 1'b0;
  int r0;
  int a0;

  always #5 clk = ~clk;

  cipher_host_bridge #(
    .OUT_DEPTH     (Depth),
    .TIMEOUT_CYCLES(Tmo)
  ) dut (
    .clk                      (clk),
    .nrst                     (nrst),
    .in_byte                  (in_byte),
    .in_is_key                (in_is_key),
    .in_reset_hash            (in_reset_hash),
    .in_valid                 (in_valid),
    .in_ready                 (in_ready),
    .core_input_byte          (core_input_byte),
    .core_is_key              (core_is_key),
    .core_reset_hash          (core_reset_hash),
    .core_input_request       (core_input_request),
    .core_input_acknowledged  (core_input_acknowledged),
    .core_output_byte_is_ready(core_output_byte_is_ready),
    .core_output_byte         (core_output_byte),
    .core_output_acknowledge  (core_output_acknowledge),
    .out_byte                 (out_byte),
    .out_valid                (out_valid),
    .out_ready                (out_ready),
    .fifo_count               (fifo_count),
    .timeout_err              (timeout_err)
  );

  // Handshake activity monitor: request pulses and acknowledge cycles.
  always @(posedge clk) begin
    if (core_input_request && !req_prev) req_rises <= req_rises + 1;
    if (core_output_acknowledge) oack_cycles <= oack_cycles + 1;
    req_prev <= core_input_request;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Full command transaction with a prompt core; starts and ends on a negedge.
  task automatic xfer(input logic [7:0] b, input logic key, input logic rh,
                      input logic [7:0] c, input logic pop_now);
    in_byte = b; in_is_key = key; in_reset_hash = rh; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; core_input_acknowledged = 1'b1;
    @(negedge clk);
    core_input_acknowledged = 1'b0;
    @(negedge clk);
    if (!key && !rh) begin
      core_output_byte = c; core_output_byte_is_ready = 1'b1; out_ready = pop_now;
      @(negedge clk);
      core_output_byte_is_ready = 1'b0; out_ready = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic pop_one(input string tag, input logic [7:0] exp);
    chk({tag, "_valid"}, out_valid, 1);
    chk(tag, out_byte, exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    nrst = 1'b0; in_byte = '0; in_is_key = 0; in_reset_hash = 0; in_valid = 0;
    core_input_acknowledged = 0; core_output_byte_is_ready = 0;
    core_output_byte = '0; out_ready = 0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_state", dut.r_state, StIdle);
    chk("rst_req", core_input_request, 0);
    chk("rst_oack", core_output_acknowledge, 0);
    chk("rst_cbyte", core_input_byte, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovalid", out_valid, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_inrdy", in_ready, 1);
    nrst = 1'b1;
    @(negedge clk);

    // Key byte 0x2B: IDLE -> REQ_HI -> REQ_LO -> IDLE, no output side activity
    a0 = oack_cycles;
    in_byte = 8'h2B; in_is_key = 1'b1; in_valid = 1'b1;
    chk("key_inrdy", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0; in_is_key = 1'b0; in_byte = 8'hFF;
    chk("key_st_hi", dut.r_state, StReqHi);
    chk("key_req", core_input_request, 1);
    chk("key_cbyte", core_input_byte, 8'h2B);
    chk("key_iskey", core_is_key, 1);
    core_input_acknowledged = 1'b1;
    @(negedge clk);
    chk("key_st_lo", dut.r_state, StReqLo);
    chk("key_req_lo", core_input_request, 0);
    chk("key_inrdy_busy", in_ready, 0);
    core_input_acknowledged = 1'b0;
    @(negedge clk);
    chk("key_st_idle", dut.r_state, StIdle);
    chk("key_count", fifo_count, 0);
    chk("key_no_oack", oack_cycles - a0, 0);

    // Data byte 0x41, core acknowledges after 3 cycles, returns 0x9C
    r0 = req_rises;
    in_byte = 8'h41; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("d41_req", core_input_request, 1);
    chk("d41_cbyte", core_input_byte, 8'h41);
    repeat (2) @(negedge clk);
    chk("d41_req_held", core_input_request, 1);
    core_input_acknowledged = 1'b1;
    @(negedge clk);
    chk("d41_st_lo", dut.r_state, StReqLo);
    core_input_acknowledged = 1'b0;
    @(negedge clk);
    chk("d41_st_ow", dut.r_state, StOutWait);
    chk("d41_no_early", out_valid, 0);
    core_output_byte = 8'h9C; core_output_byte_is_ready = 1'b1;
    @(negedge clk);
    chk("d41_oack", core_output_acknowledge, 1);
    chk("d41_ovalid", out_valid, 1);
    chk("d41_obyte", out_byte, 8'h9C);
    chk("d41_count", fifo_count, 1);
    core_output_byte_is_ready = 1'b0;
    @(negedge clk);
    chk("d41_oack_clr", core_output_acknowledge, 0);
    chk("d41_st_idle", dut.r_state, StIdle);
    chk("d41_one_pulse", req_rises - r0, 1);

    // reset_hash command produces no ciphertext
    xfer(8'h00, 1'b0, 1'b1, 8'hEE, 1'b0);
    chk("rh_count", fifo_count, 1);
    chk("rh_flag", core_reset_hash, 1);
    chk("rh_idle", dut.r_state, StIdle);

    // Fill to depth with out_ready low, then pop one and accept a fifth
    pop_one("pop_9c", 8'h9C);
    chk("empty_count", fifo_count, 0);
    xfer(8'h01, 1'b0, 1'b0, 8'h11, 1'b0);
    xfer(8'h02, 1'b0, 1'b0, 8'h22, 1'b0);
    xfer(8'h03, 1'b0, 1'b0, 8'h33, 1'b0);
    xfer(8'h04, 1'b0, 1'b0, 8'h44, 1'b0);
    chk("full_count", fifo_count, 4);
    chk("full_inrdy", in_ready, 0);
    in_byte = 8'h05; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("full_no_accept", dut.r_state, StIdle);
    chk("full_no_req", core_input_request, 0);
    pop_one("pop_11", 8'h11);
    chk("pop1_count", fifo_count, 3);
    chk("pop1_inrdy", in_ready, 1);
    xfer(8'h05, 1'b0, 1'b0, 8'h55, 1'b0);
    chk("refill_count", fifo_count, 4);
    pop_one("pop_22", 8'h22);
    pop_one("pop_33", 8'h33);
    pop_one("pop_44", 8'h44);
    pop_one("pop_55", 8'h55);
    chk("drain_count", fifo_count, 0);
    chk("drain_ovalid", out_valid, 0);

    // Pointers now at 2; place head at index 3 with count 2, then push+pop
    xfer(8'h06, 1'b0, 1'b0, 8'h61, 1'b0);
    xfer(8'h07, 1'b0, 1'b0, 8'h62, 1'b0);
    pop_one("pop_61", 8'h61);
    xfer(8'h08, 1'b0, 1'b0, 8'h63, 1'b0);
    chk("wrap_pre_count", fifo_count, 2);
    chk("wrap_pre_head", out_byte, 8'h62);
    xfer(8'h09, 1'b0, 1'b0, 8'h64, 1'b1);
    chk("wrap_count", fifo_count, 2);
    chk("wrap_head", out_byte, 8'h63);
    xfer(8'h0A, 1'b0, 1'b0, 8'h65, 1'b0);
    chk("three_count", fifo_count, 3);

    // Asynchronous reset while waiting for the core's output byte
    in_byte = 8'h77; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; core_input_acknowledged = 1'b1;
    @(negedge clk);
    core_input_acknowledged = 1'b0;
    @(negedge clk);
    chk("ar_st_ow", dut.r_state, StOutWait);
    chk("ar_pre_count", fifo_count, 3);
    chk("ar_pre_cbyte", core_input_byte, 8'h77);
    #2 nrst = 1'b0;
    #1;
    chk("ar_state", dut.r_state, StIdle);
    chk("ar_req", core_input_request, 0);
    chk("ar_oack", core_output_acknowledge, 0);
    chk("ar_cbyte", core_input_byte, 0);
    chk("ar_count", fifo_count, 0);
    chk("ar_ovalid", out_valid, 0);
    chk("ar_terr", timeout_err, 0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    // Core never acknowledges
    in_byte = 8'h5A; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("to_req", core_input_request, 1);
`ifdef CIPHER_HOST_BRIDGE_TIMEOUT_EN
    repeat (7) @(negedge clk);
    chk("to_still_hi", dut.r_state, StReqHi);
    chk("to_no_err_yet", timeout_err, 0);
    @(negedge clk);
    chk("to_err", timeout_err, 1);
    chk("to_req_clr", core_input_request, 0);
    chk("to_idle", dut.r_state, StIdle);
    @(negedge clk);
    chk("to_sticky", timeout_err, 1);
`else
    repeat (20) @(negedge clk);
    chk("nto_req_held", core_input_request, 1);
    chk("nto_state", dut.r_state, StReqHi);
    chk("nto_terr", timeout_err, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
